bingo_ball_drawer: RTL and testbench

//   Draws bingo balls 1..MAX_BALL without repetition, one per request.

---
 rtl/bingo_ball_drawer.sv | 120 ++++++++++++
 tb/tb_bingo_ball_drawer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bingo_ball_drawer.sv
// Draws bingo balls 1..MAX_BALL without repetition: folds the PRNG value into
// a candidate, linearly probes past balls already drawn, presents on valid/ready.
module bingo_ball_drawer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BALL   = 75,
  parameter int BALL_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_game,
  input  logic                  draw_req,
  input  logic [DATA_WIDTH-1:0] prng_number,
  output logic                  prng_enable,
  output logic                  busy,
  output logic [BALL_WIDTH-1:0] ball,
  output logic                  ball_valid,
  input  logic                  ball_ready,
  output logic [BALL_WIDTH-1:0] drawn_count,
  output logic                  all_drawn
);

  localparam int NSLOT = 2**BALL_WIDTH;
  localparam logic [BALL_WIDTH-1:0] MAX_B = BALL_WIDTH'(MAX_BALL);

  typedef enum logic [1:0] {IDLE, SAMPLE, PROBE, PRESENT} state_t;

  state_t                  state_q, state_d;
  logic [NSLOT-1:0]        drawn_q, drawn_d;
  logic [BALL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [BALL_WIDTH-1:0]   ball_q, ball_d;
  logic                    ball_valid_q, ball_valid_d;
  logic [BALL_WIDTH-1:0]   count_q, count_d;
  logic                    prng_en_q;
  logic [BALL_WIDTH-1:0]   raw, cand;
  logic                    prng_unused;

  // Only the low BALL_WIDTH bits feed the fold; the rest is intentionally dropped.
  assign prng_unused = ^prng_number;
  assign raw         = prng_number[BALL_WIDTH-1:0];

  always_comb begin
    cand = raw;
    if (raw == '0)        cand = BALL_WIDTH'(1);
    else if (raw > MAX_B) cand = raw - MAX_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      drawn_q      <= '0;
      ptr_q        <= BALL_WIDTH'(1);
      ball_q       <= '0;
      ball_valid_q <= 1'b0;
      count_q      <= '0;
      prng_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      drawn_q      <= drawn_d;
      ptr_q        <= ptr_d;
      ball_q       <= ball_d;
      ball_valid_q <= ball_valid_d;
      count_q      <= count_d;
      prng_en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (draw_req && !all_drawn) state_d = SAMPLE;
        SAMPLE:  state_d = PROBE;
        PROBE:   if (!drawn_q[ptr_q]) state_d = PRESENT;
        PRESENT: if (ball_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Probe walks 1..MAX_BALL cyclically, so a free slot is found within MAX_BALL cycles.
  always_comb begin
    drawn_d      = drawn_q;
    ptr_d        = ptr_q;
    ball_d       = ball_q;
    ball_valid_d = ball_valid_q;
    count_d      = count_q;
    if (new_game) begin
      drawn_d      = '0;
      count_d      = '0;
      ball_valid_d = 1'b0;
    end else begin
      case (state_q)
        SAMPLE: ptr_d = cand;
        PROBE: begin
          if (!drawn_q[ptr_q]) begin
            drawn_d[ptr_q] = 1'b1;
            ball_d         = ptr_q;
            ball_valid_d   = 1'b1;
            count_d        = count_q + BALL_WIDTH'(1);
          end else begin
            ptr_d = (ptr_q == MAX_B) ? BALL_WIDTH'(1) : ptr_q + BALL_WIDTH'(1);
          end
        end
        PRESENT: if (ball_ready) ball_valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    prng_enable = prng_en_q;
    ball        = ball_q;
    ball_valid  = ball_valid_q;
    drawn_count = count_q;
    all_drawn   = (count_q == MAX_B);
  end

endmodule

// File: tb/tb_bingo_ball_drawer.sv
// Directed plus randomized draws of bingo_ball_drawer against a set-of-drawn-balls model.
module tb_bingo_ball_drawer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic       draw_req = 1'b0;
  logic [7:0] prng_number = 8'h00;
  logic       prng_enable, busy, ball_valid, all_drawn;
  logic       ball_ready = 1'b0;
  logic [6:0] ball, drawn_count;

  int checks = 0;
  int errors = 0;

  bit mdl_drawn [1:75];
  int mdl_count = 0;

  bingo_ball_drawer #(.DATA_WIDTH(8), .MAX_BALL(75), .BALL_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .draw_req(draw_req),
    .prng_number(prng_number), .prng_enable(prng_enable), .busy(busy),
    .ball(ball), .ball_valid(ball_valid), .ball_ready(ball_ready),
    .drawn_count(drawn_count), .all_drawn(all_drawn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 1; i <= 75; i++) mdl_drawn[i] = 1'b0;
    mdl_count = 0;
  endtask

  // Expected ball: fold the value into 1..75, then take the next undrawn ball cyclically.
  task automatic model_pick(input logic [7:0] p, output int b, output int coll);
    int r;
    r = p % 128;
    b = (r == 0) ? 1 : (r > 75) ? r - 75 : r;
    coll = 0;
    while (mdl_drawn[b]) begin
      b = (b % 75) + 1;
      coll++;
    end
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_clear();
  endtask

  // One full draw; hold = cycles with ready low in PRESENT; no_ack leaves it in PRESENT.
  task automatic do_draw(input logic [7:0] p, input int hold, input bit no_ack);
    int eb, coll, lat;
    model_pick(p, eb, coll);
    prng_number = p;
    draw_req    = 1'b1;
    @(posedge clk); #1;
    draw_req = 1'b0;
    lat = 1;
    while (!ball_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= 2) prng_number = 8'($urandom);
    end
    mdl_drawn[eb] = 1'b1;
    mdl_count++;
    check("latency", lat, 3 + coll);
    check("ball", ball, eb);
    check("count", drawn_count, mdl_count);
    check("all_drawn", all_drawn, mdl_count == 75);
    if (!no_ack) begin
      for (int i = 0; i < hold; i++) begin
        draw_req    = 1'($urandom);
        prng_number = 8'($urandom);
        @(posedge clk); #1;
        check("hold_valid", ball_valid, 1);
        check("hold_ball", ball, eb);
      end
      ball_ready = 1'b1;
      @(posedge clk); #1;
      ball_ready = 1'b0;
      draw_req   = 1'b0;
      check("ack_valid", ball_valid, 0);
      check("ack_busy", busy, 0);
      check("ack_ball_kept", ball, eb);
    end
  endtask

  initial begin
    int eb, coll;
    model_clear();
    @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_valid", ball_valid, 0);
    check("rst_ball", ball, 0);
    check("rst_count", drawn_count, 0);
    check("rst_all", all_drawn, 0);
    check("rst_prng_en", prng_enable, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("prng_en_on", prng_enable, 1);

    // First draw and a forced collision
    do_draw(8'h05, 0, 1'b0);
    do_draw(8'h05, 0, 1'b0);

    // Fold corners, each on a fresh game so no probing happens
    pulse_new_game(); do_draw(8'hC8, 0, 1'b0);
    pulse_new_game(); do_draw(8'h7F, 0, 1'b0);
    pulse_new_game(); do_draw(8'h00, 0, 1'b0);
    pulse_new_game(); do_draw(8'h4C, 0, 1'b0);

    // Stuck PRNG fills the board in order
    pulse_new_game();
    for (int i = 0; i < 75; i++) do_draw(8'h00, 0, 1'b0);
    check("full_all", all_drawn, 1);
    check("full_count", drawn_count, 75);
    draw_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("full_ignored", busy, 0);
    end
    draw_req = 1'b0;

    // Long backpressure, then ready stays high: exactly one handshake
    pulse_new_game();
    do_draw(8'h21, 10, 1'b0);
    ball_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ball_ready = 1'b0;
    check("one_hs_count", drawn_count, 1);
    check("one_hs_busy", busy, 0);

    // new_game while probing
    prng_number = 8'h10;
    draw_req = 1'b1;
    @(posedge clk); #1;
    draw_req = 1'b0;
    @(posedge clk); #1;
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_clear();
    check("ng_probe_valid", ball_valid, 0);
    check("ng_probe_count", drawn_count, 0);
    check("ng_probe_busy", busy, 0);

    // new_game while presenting, racing a draw_req
    do_draw(8'h33, 0, 1'b1);
    new_game = 1'b1;
    draw_req = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    draw_req = 1'b0;
    model_clear();
    check("ng_pres_valid", ball_valid, 0);
    check("ng_pres_count", drawn_count, 0);
    check("ng_pres_busy", busy, 0);

    // Randomized draws with random backpressure
    for (int i = 0; i < 40; i++) do_draw(8'($urandom), $urandom_range(0, 3), 1'b0);

    // Async reset while probing
    model_pick(8'h44, eb, coll);
    prng_number = 8'h44;
    draw_req = 1'b1;
    @(posedge clk); #1;
    draw_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", ball_valid, 0);
    check("arst_ball", ball, 0);
    check("arst_count", drawn_count, 0);
    check("arst_all", all_drawn, 0);
    check("arst_prng_en", prng_enable, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    check("arst_prng_en_on", prng_enable, 1);
    do_draw(8'h44, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
